// File: rtl/lcd_bus_monitor_if.sv
// LCD parallel bus as driven by a host (master) and observed by a passive monitor (slave).
interface lcd_bus_monitor_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;

   modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en);
   modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_en);
endinterface

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780-style bus monitor: decodes committed LCD transfers into a 2x16 shadow
// of the display plus cursor/mode state, with a multi-cycle clear-display fill.
module lcd_bus_monitor #(
   parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
   input  logic             clk2,
   input  logic             rst,
   lcd_bus_monitor_if.slave bus,
   input  logic [4:0]       rd_addr,
   output logic [7:0]       rd_char,
   output logic [6:0]       cursor,
   output logic             disp_on,
   output logic             cursor_on,
   output logic             blink_on,
   output logic             incr,
   output logic             two_line,
   output logic             busy,
   output logic             cmd_strobe,
   output logic             char_strobe,
   output logic             err
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLR = 1'b1} state_t;

   logic       r_en_s1, r_en_s2, r_en_s3;
   logic       r_rs_s1, r_rs_s2;
   logic       r_rw_s1, r_rw_s2;
   logic [7:0] r_data_s1, r_data_s2;
   logic       r_pend_vld, r_pend_rs, r_pend_rw;
   logic [7:0] r_pend_data;

   state_t     r_state;
   logic [4:0] r_clr_idx;
   logic [6:0] r_cursor;
   logic       r_disp_on, r_cursor_on, r_blink_on, r_incr, r_two_line;
   logic       r_busy, r_cmd_strobe, r_char_strobe, r_err;
   logic [7:0] r_rd_char;
   logic [7:0] r_mem [0:31];

   logic       w_mem_we;
   logic [4:0] w_mem_addr;
   logic [7:0] w_mem_wdata;

   // Next DDRAM address after a character write; the two lines form one 32-cell ring.
   function automatic logic [6:0] f_step(input logic [6:0] c, input logic up);
      logic [6:0] n;
      if (up) begin
         if (c == 7'h0F)      n = 7'h40;
         else if (c == 7'h4F) n = 7'h00;
         else                 n = c + 7'd1;
      end else begin
         if (c == 7'h00)      n = 7'h4F;
         else if (c == 7'h40) n = 7'h0F;
         else                 n = c - 7'd1;
      end
      return n;
   endfunction

   // Bus synchronizers, falling-edge detect and transfer capture stage.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         r_en_s1     <= 1'b1;
         r_en_s2     <= 1'b1;
         r_en_s3     <= 1'b1;
         r_rs_s1     <= 1'b0;
         r_rs_s2     <= 1'b0;
         r_rw_s1     <= 1'b0;
         r_rw_s2     <= 1'b0;
         r_data_s1   <= 8'h00;
         r_data_s2   <= 8'h00;
         r_pend_vld  <= 1'b0;
         r_pend_rs   <= 1'b0;
         r_pend_rw   <= 1'b0;
         r_pend_data <= 8'h00;
      end else begin
         r_en_s1     <= bus.lcd_en;
         r_en_s2     <= r_en_s1;
         r_en_s3     <= r_en_s2;
         r_rs_s1     <= bus.lcd_rs;
         r_rs_s2     <= r_rs_s1;
         r_rw_s1     <= bus.lcd_rw;
         r_rw_s2     <= r_rw_s1;
         r_data_s1   <= bus.lcd_data;
         r_data_s2   <= r_data_s1;
         r_pend_vld  <= r_en_s3 & ~r_en_s2;
         r_pend_rs   <= r_rs_s2;
         r_pend_rw   <= r_rw_s2;
         r_pend_data <= r_data_s2;
      end
   end

   // Control FSM: commits captured transfers and sequences the clear fill.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_clr_idx     <= 5'd0;
         r_cursor      <= 7'h00;
         r_disp_on     <= 1'b0;
         r_cursor_on   <= 1'b0;
         r_blink_on    <= 1'b0;
         r_incr        <= 1'b1;
         r_two_line    <= 1'b0;
         r_busy        <= 1'b0;
         r_cmd_strobe  <= 1'b0;
         r_char_strobe <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_cmd_strobe  <= 1'b0;
         r_char_strobe <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_pend_vld) begin
                  if (r_pend_rw) begin
                     r_err <= 1'b1;
                  end else if (r_pend_rs) begin
                     r_char_strobe <= 1'b1;
                     r_cursor      <= f_step(r_cursor, r_incr);
                  end else begin
                     r_cmd_strobe <= 1'b1;
                     casez (r_pend_data)
                        8'b1???????: begin
                           // Addresses outside the two 16-cell windows fold onto them.
                           r_cursor <= {r_pend_data[6], 2'b00, r_pend_data[3:0]};
                           if (|r_pend_data[5:4]) r_err <= 1'b1;
                        end
                        8'b01??????: begin end
                        8'b001?????: r_two_line <= r_pend_data[3];
                        8'b0001????: begin end
                        8'b00001???: {r_disp_on, r_cursor_on, r_blink_on} <= r_pend_data[2:0];
                        8'b000001??: r_incr <= r_pend_data[1];
                        8'b0000001?: r_cursor <= 7'h00;
                        8'b00000001: begin
                           r_state   <= ST_CLR;
                           r_busy    <= 1'b1;
                           r_clr_idx <= 5'd0;
                        end
                        default: begin end
                     endcase
                  end
               end
            end
            ST_CLR: begin
               if (r_pend_vld) r_err <= 1'b1;
               if (r_clr_idx == 5'd31) begin
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
                  r_cursor <= 7'h00;
                  r_incr   <= 1'b1;
               end else begin
                  r_clr_idx <= r_clr_idx + 5'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Shadow write port: clear fill has priority, dropped transfers never write.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = 5'd0;
      w_mem_wdata = 8'h00;
      if (r_state == ST_CLR) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_idx;
         w_mem_wdata = CLEAR_CHAR;
      end else if (r_pend_vld && !r_pend_rw && r_pend_rs) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = {r_cursor[6], r_cursor[3:0]};
         w_mem_wdata = r_pend_data;
      end else begin
         w_mem_we    = 1'b0;
         w_mem_addr  = 5'd0;
         w_mem_wdata = 8'h00;
      end
   end

   // Shadow storage, intentionally without reset.
   always_ff @(posedge clk2) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   // Registered read port; same-cycle collisions return the old contents.
   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) r_rd_char <= 8'h00;
      else      r_rd_char <= r_mem[rd_addr];
   end

   assign rd_char     = r_rd_char;
   assign cursor      = r_cursor;
   assign disp_on     = r_disp_on;
   assign cursor_on   = r_cursor_on;
   assign blink_on    = r_blink_on;
   assign incr        = r_incr;
   assign two_line    = r_two_line;
   assign busy        = r_busy;
   assign cmd_strobe  = r_cmd_strobe;
   assign char_strobe = r_char_strobe;
   assign err         = r_err;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Self-checking bench for lcd_bus_monitor: directed scenarios plus randomized transfers
// compared against a line/column model of the display shadow.
module tb_lcd_bus_monitor;
   logic       clk2 = 1'b0;
   logic       rst;
   logic [4:0] rd_addr;
   logic [7:0] rd_char;
   logic [6:0] cursor;
   logic       disp_on, cursor_on, blink_on, incr, two_line, busy, cmd_strobe, char_strobe, err;

   always #5 clk2 = ~clk2;

   lcd_bus_monitor_if bus_if ();

   lcd_bus_monitor #(.CLEAR_CHAR(8'h20)) dut (
      .clk2(clk2), .rst(rst), .bus(bus_if), .rd_addr(rd_addr), .rd_char(rd_char),
      .cursor(cursor), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .incr(incr), .two_line(two_line), .busy(busy), .cmd_strobe(cmd_strobe),
      .char_strobe(char_strobe), .err(err)
   );

   int checks = 0;
   int failures = 0;
   int cnt_cmd = 0, cnt_chr = 0, cnt_both = 0, cnt_busy = 0;

   // model: cursor kept as DDRAM address, cells as linear 0..31
   logic [6:0] m_cursor;
   bit         m_incr, m_disp, m_curon, m_blink, m_two, m_err;
   logic [7:0] m_mem [32];

   always @(negedge clk2) begin
      if (cmd_strobe) cnt_cmd++;
      if (char_strobe) cnt_chr++;
      if (cmd_strobe && char_strobe) cnt_both++;
      if (busy) cnt_busy++;
   end

   task automatic model_reset();
      m_cursor = 7'h00; m_incr = 1'b1; m_two = 1'b0;
      m_disp = 1'b0; m_curon = 1'b0; m_blink = 1'b0; m_err = 1'b0;
   endtask

   // kind: 0 = no strobe, 1 = command, 2 = character
   task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d,
                              input bit in_busy, output int kind);
      int hb;
      int p;
      kind = 0;
      if (in_busy || rw) begin
         m_err = 1'b1;
         return;
      end
      if (rs) begin
         p = int'(m_cursor[6]) * 16 + int'(m_cursor[3:0]);
         m_mem[p] = d;
         p = m_incr ? (p + 1) % 32 : (p + 31) % 32;
         m_cursor = 7'((p / 16) * 64 + (p % 16));
         kind = 2;
         return;
      end
      kind = 1;
      hb = -1;
      for (int b = 7; b >= 0; b--) if (d[b] && hb < 0) hb = b;
      case (hb)
         7: begin
            m_cursor = 7'(int'(d[6]) * 64 + int'(d[3:0]));
            if (d[5:4] != 2'b00) m_err = 1'b1;
         end
         5: m_two = d[3];
         3: begin m_disp = d[2]; m_curon = d[1]; m_blink = d[0]; end
         2: m_incr = d[1];
         1: m_cursor = 7'h00;
         0: begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_cursor = 7'h00;
            m_incr = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
      @(negedge clk2);
      bus_if.lcd_rs = rs; bus_if.lcd_rw = rw; bus_if.lcd_data = d;
      @(negedge clk2);
      bus_if.lcd_en = 1'b0;
      repeat (2) @(negedge clk2);
      bus_if.lcd_en = 1'b1;
      repeat (4) @(negedge clk2);
   endtask

   task automatic send(input bit rs, input bit rw, input logic [7:0] d);
      int k;
      model_apply(rs, rw, d, 1'b0, k);
      xfer(rs, rw, d);
   endtask

   task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
      @(negedge clk2);
      rd_addr = a;
      @(negedge clk2);
      v = rd_char;
   endtask

   task automatic apply_reset();
      @(negedge clk2);
      rst = 1'b0;
      bus_if.lcd_en = 1'b1; bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h00;
      repeat (2) @(negedge clk2);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk2);
   endtask

   task automatic test_reset();
      rst = 1'b0; rd_addr = 5'd0;
      bus_if.lcd_en = 1'b1; bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h00;
      repeat (3) @(negedge clk2);
      checks++;
      if ({cursor, incr, two_line, disp_on, cursor_on, blink_on} !== {7'h00, 1'b1, 4'b0000}) begin
         failures++;
         $display("FAIL reset_state: got cursor=%h incr=%b two=%b d/c/b=%b%b%b", cursor, incr,
                  two_line, disp_on, cursor_on, blink_on);
      end
      checks++;
      if ({busy, cmd_strobe, char_strobe, err, rd_char} !== {4'b0000, 8'h00}) begin
         failures++;
         $display("FAIL reset_misc: got busy=%b strobes=%b%b err=%b rd_char=%h", busy, cmd_strobe,
                  char_strobe, err, rd_char);
      end
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk2);
   endtask

   task automatic test_latency();
      int n;
      int k;
      @(negedge clk2);
      bus_if.lcd_rs = 1'b0; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h10;
      @(negedge clk2);
      bus_if.lcd_en = 1'b0;
      n = 0;
      while (n < 10) begin
         @(posedge clk2);
         #1;
         n++;
         if (cmd_strobe) break;
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL commit_latency: strobe after %0d edges, expected 4", n);
      end
      bus_if.lcd_en = 1'b1;
      model_apply(1'b0, 1'b0, 8'h10, 1'b0, k);
      repeat (4) @(negedge clk2);
   endtask

   task automatic test_init();
      int c0;
      c0 = cnt_cmd;
      send(1'b0, 1'b0, 8'h38);
      send(1'b0, 1'b0, 8'h0C);
      send(1'b0, 1'b0, 8'h06);
      checks++;
      if ({two_line, disp_on, cursor_on, blink_on, incr, err} !== 6'b110010) begin
         failures++;
         $display("FAIL init_flags: got two=%b d/c/b=%b%b%b incr=%b err=%b expected 1 100 1 0",
                  two_line, disp_on, cursor_on, blink_on, incr, err);
      end
      checks++;
      if (cnt_cmd - c0 !== 3) begin
         failures++;
         $display("FAIL init_strobes: got %0d cmd strobes, expected 3", cnt_cmd - c0);
      end
   endtask

   task automatic test_chars();
      logic [7:0] exp_c [5];
      logic [7:0] v;
      int c0;
      exp_c[0] = 8'h44; exp_c[1] = 8'h45; exp_c[2] = 8'h46; exp_c[3] = 8'h45; exp_c[4] = 8'h41;
      send(1'b0, 1'b0, 8'hC0);
      c0 = cnt_chr;
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0, exp_c[i]);
      checks++;
      if (cursor !== 7'h45) begin
         failures++;
         $display("FAIL chars_cursor: got %h expected 45", cursor);
      end
      checks++;
      if (cnt_chr - c0 !== 5) begin
         failures++;
         $display("FAIL chars_strobes: got %0d expected 5", cnt_chr - c0);
      end
      for (int i = 0; i < 5; i++) begin
         read_cell(5'(16 + i), v);
         checks++;
         if (v !== exp_c[i]) begin
            failures++;
            $display("FAIL chars_cell%0d: got %h expected %h", 16 + i, v, exp_c[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      logic [6:0] exp_cur [4];
      logic [7:0] addr_cmd [4];
      exp_cur[0] = 7'h40; exp_cur[1] = 7'h00; exp_cur[2] = 7'h4F; exp_cur[3] = 7'h0F;
      addr_cmd[0] = 8'h8F; addr_cmd[1] = 8'hCF; addr_cmd[2] = 8'h80; addr_cmd[3] = 8'hC0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) send(1'b0, 1'b0, 8'h04);
         send(1'b0, 1'b0, addr_cmd[i]);
         send(1'b1, 1'b0, (i == 0) ? 8'h58 : 8'h59);
         checks++;
         if (cursor !== exp_cur[i]) begin
            failures++;
            $display("FAIL wrap_cursor%0d: got %h expected %h", i, cursor, exp_cur[i]);
         end
      end
      send(1'b0, 1'b0, 8'h06);
      read_cell(5'd15, v);
      checks++;
      if (v !== 8'h58) begin
         failures++;
         $display("FAIL wrap_cell15: got %h expected 58", v);
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL wrap_err: got %b expected 0", err);
      end
   endtask

   task automatic test_clear();
      int b0, ch0, k;
      logic [7:0] v;
      b0 = cnt_busy;
      ch0 = cnt_chr;
      send(1'b0, 1'b0, 8'h01);
      model_apply(1'b1, 1'b0, 8'h51, 1'b1, k);
      xfer(1'b1, 1'b0, 8'h51);
      repeat (45) @(negedge clk2);
      checks++;
      if (cnt_busy - b0 !== 32) begin
         failures++;
         $display("FAIL clear_busy_len: got %0d cycles expected 32", cnt_busy - b0);
      end
      checks++;
      if ({busy, err, incr, cursor} !== {3'b011, 7'h00} || cnt_chr != ch0) begin
         failures++;
         $display("FAIL clear_state: got busy=%b err=%b incr=%b cursor=%h chars=%0d", busy, err,
                  incr, cursor, cnt_chr - ch0);
      end
      for (int i = 0; i < 32; i++) begin
         read_cell(5'(i), v);
         checks++;
         if (v !== 8'h20) begin
            failures++;
            $display("FAIL clear_cell%0d: got %h expected 20", i, v);
         end
      end
      // read of cell 0 collides with a character write into cell 0
      @(negedge clk2);
      rd_addr = 5'd0;
      bus_if.lcd_rs = 1'b1; bus_if.lcd_rw = 1'b0; bus_if.lcd_data = 8'h5A;
      @(negedge clk2);
      bus_if.lcd_en = 1'b0;
      repeat (4) @(posedge clk2);
      #1;
      checks++;
      if (rd_char !== 8'h20) begin
         failures++;
         $display("FAIL rdw_old: got %h expected 20", rd_char);
      end
      @(posedge clk2);
      #1;
      checks++;
      if (rd_char !== 8'h5A) begin
         failures++;
         $display("FAIL rdw_new: got %h expected 5a", rd_char);
      end
      bus_if.lcd_en = 1'b1;
      model_apply(1'b1, 1'b0, 8'h5A, 1'b0, k);
      repeat (4) @(negedge clk2);
   endtask

   task automatic test_read_setaddr();
      int c0, ch0;
      apply_reset();
      c0 = cnt_cmd; ch0 = cnt_chr;
      send(1'b0, 1'b1, 8'h80);
      checks++;
      if (err !== 1'b1 || cnt_cmd != c0 || cnt_chr != ch0 || cursor !== 7'h00) begin
         failures++;
         $display("FAIL read_xfer: got err=%b strobes=%0d/%0d cursor=%h expected 1 0/0 00", err,
                  cnt_cmd - c0, cnt_chr - ch0, cursor);
      end
      apply_reset();
      send(1'b0, 1'b0, 8'h95);
      checks++;
      if (cursor !== 7'h05 || err !== 1'b1) begin
         failures++;
         $display("FAIL bad_addr: got cursor=%h err=%b expected 05 1", cursor, err);
      end
   endtask

   task automatic test_random();
      bit rs, rw;
      logic [7:0] d, v;
      int k, c0, ch0;
      for (int it = 0; it < 60; it++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 9) == 0);
         d = 8'($urandom);
         if (!rs && d == 8'h01) d = 8'h02;
         c0 = cnt_cmd; ch0 = cnt_chr;
         model_apply(rs, rw, d, 1'b0, k);
         xfer(rs, rw, d);
         checks++;
         if (cursor !== m_cursor || err !== m_err) begin
            failures++;
            $display("FAIL rand%0d_cursor: got %h err=%b expected %h err=%b (d=%h rs=%b rw=%b)", it,
                     cursor, err, m_cursor, m_err, d, rs, rw);
         end
         checks++;
         if ({incr, two_line, disp_on, cursor_on, blink_on} !== {m_incr, m_two, m_disp, m_curon, m_blink}) begin
            failures++;
            $display("FAIL rand%0d_flags: got %b%b%b%b%b expected %b%b%b%b%b", it, incr, two_line,
                     disp_on, cursor_on, blink_on, m_incr, m_two, m_disp, m_curon, m_blink);
         end
         checks++;
         if ((cnt_cmd - c0) != int'(k == 1) || (cnt_chr - ch0) != int'(k == 2)) begin
            failures++;
            $display("FAIL rand%0d_strobe: got cmd=%0d chr=%0d expected kind %0d", it,
                     cnt_cmd - c0, cnt_chr - ch0, k);
         end
      end
      for (int i = 0; i < 32; i++) begin
         read_cell(5'(i), v);
         checks++;
         if (v !== m_mem[i]) begin
            failures++;
            $display("FAIL rand_cell%0d: got %h expected %h", i, v, m_mem[i]);
         end
      end
   endtask

   task automatic test_reset_midclear();
      send(1'b0, 1'b0, 8'h3C);
      send(1'b0, 1'b0, 8'h0F);
      send(1'b0, 1'b0, 8'h01);
      repeat (5) @(negedge clk2);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL midclear_busy: got %b expected 1", busy);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, cursor, incr, two_line, disp_on, cursor_on, blink_on, err, cmd_strobe, char_strobe}
          !== {1'b0, 7'h00, 1'b1, 7'b0000000}) begin
         failures++;
         $display("FAIL midclear_reset: got busy=%b cursor=%h incr=%b two=%b dcb=%b%b%b err=%b", busy,
                  cursor, incr, two_line, disp_on, cursor_on, blink_on, err);
      end
      repeat (2) @(negedge clk2);
      rst = 1'b1;
      model_reset();
      repeat (40) @(negedge clk2);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL midclear_after: busy got %b expected 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_init();
      test_chars();
      test_wrap();
      test_clear();
      test_read_setaddr();
      test_random();
      test_reset_midclear();
      checks++;
      if (cnt_both != 0) begin
         failures++;
         $display("FAIL strobe_overlap: got %0d cycles with both strobes, expected 0", cnt_both);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
